// File: rtl/wb_arbiter_if.sv
// FU-result and writeback bus between the functional units, the writeback arbiter and the ROB.
// master = FU lanes plus ROB side; slave = arbiter side.
interface wb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 64
);
    localparam int FU_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]        fu_valid_in;
    logic [NUM_FU*TAG_W-1:0]  fu_tag_in;
    logic [NUM_FU*DATA_W-1:0] fu_data_in;
    logic [NUM_FU-1:0]        fu_exc_in;
    logic [NUM_FU-1:0]        fu_ready_out;
    logic                     wb_valid_out;
    logic [TAG_W-1:0]         wb_tag_out;
    logic [DATA_W-1:0]        wb_data_out;
    logic                     wb_exc_out;
    logic [FU_W-1:0]          wb_fu_out;
    logic                     wb_ready_in;

    modport master (
        output fu_valid_in, fu_tag_in, fu_data_in, fu_exc_in, wb_ready_in,
        input  fu_ready_out, wb_valid_out, wb_tag_out, wb_data_out, wb_exc_out, wb_fu_out
    );

    modport slave (
        input  fu_valid_in, fu_tag_in, fu_data_in, fu_exc_in, wb_ready_in,
        output fu_ready_out, wb_valid_out, wb_tag_out, wb_data_out, wb_exc_out, wb_fu_out
    );
endinterface

// File: rtl/wb_arbiter.sv
// Per-lane result FIFO: power-of-2 depth, push/pop in the same cycle keeps the count.
// Latency: pushed entry visible at head_dat the cycle after the push edge.
// Backpressure: push_rdy comes from the registered count only; a same-cycle pop does not raise it.
module wb_lane_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk_in,
    input  logic         rst_N_in,
    input  logic         flush_in,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         nonempty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;

    assign push_rdy = (cnt_q < CNT_W'(DEPTH));
    assign push     = push_vld && push_rdy;
    assign nonempty = (cnt_q != '0);
    assign head_dat = mem[head_q];

    always_ff @(posedge clk_in) begin
        if (!rst_N_in || flush_in) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)    tail_q <= tail_q + 1'b1;
            if (pop_vld) head_q <= head_q + 1'b1;
            case ({push, pop_vld})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[tail_q] <= push_dat;
    end
endmodule

// Writeback arbiter: lane FIFOs round-robin onto one registered bus; WB_BRU_PRIORITY_EN lets lane 1 (BRU) win outright.
// Latency: FU handshake at edge N -> wb_valid_out seen at edge N+2; one writeback per cycle.
// Backpressure: wb_valid_out && !wb_ready_in holds the bus and stalls dequeue; full lanes drop fu_ready_out.
module wb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 64
) (
    input  logic          clk_in,
    input  logic          rst_N_in,
    input  logic          flush_in,
    wb_arbiter_if.slave   bus
);
    localparam int FU_W = $clog2(NUM_FU);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              exc;
    } entry_t;

    entry_t            head_e [NUM_FU];
    logic [NUM_FU-1:0] lane_rdy;
    logic [NUM_FU-1:0] lane_nonempty;
    logic [NUM_FU-1:0] lane_pop;

    entry_t            wb_q;
    logic              wb_vld_q;
    logic [FU_W-1:0]   wb_fu_q;
    logic [FU_W-1:0]   rr_q;

    logic              free;
    logic              gnt_vld;
    logic [FU_W-1:0]   gnt_idx;
    logic              rr_upd;
    logic [FU_W-1:0]   rr_nxt;
    int                scan_idx;

    assign free = !wb_vld_q || bus.wb_ready_in;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        entry_t in_e;
        assign in_e = '{tag:  bus.fu_tag_in[i*TAG_W +: TAG_W],
                        data: bus.fu_data_in[i*DATA_W +: DATA_W],
                        exc:  bus.fu_exc_in[i]};
        assign lane_pop[i] = free && gnt_vld && (gnt_idx == FU_W'(i));

        wb_lane_fifo #(
            .DEPTH (BUF_DEPTH),
            .W     ($bits(entry_t))
        ) u_fifo (
            .clk_in   (clk_in),
            .rst_N_in (rst_N_in),
            .flush_in (flush_in),
            .push_vld (bus.fu_valid_in[i]),
            .push_dat (in_e),
            .push_rdy (lane_rdy[i]),
            .pop_vld  (lane_pop[i]),
            .head_dat (head_e[i]),
            .nonempty (lane_nonempty[i])
        );
    end

    // First non-empty lane starting at rr_q; BRU override leaves rr_q alone.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = (int'(rr_q) + k) % NUM_FU;
            if (!gnt_vld && lane_nonempty[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = FU_W'(scan_idx);
            end
        end
        rr_upd = gnt_vld;
`ifdef WB_BRU_PRIORITY_EN
        if (lane_nonempty[1]) begin
            gnt_vld = 1'b1;
            gnt_idx = FU_W'(1);
            rr_upd  = 1'b0;
        end
`endif
        rr_nxt = (gnt_idx == FU_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in || flush_in) begin
            wb_vld_q <= 1'b0;
            wb_q     <= '0;
            wb_fu_q  <= '0;
            rr_q     <= '0;
        end else if (free) begin
            wb_vld_q <= gnt_vld;
            if (gnt_vld) begin
                wb_q    <= head_e[gnt_idx];
                wb_fu_q <= gnt_idx;
                if (rr_upd) rr_q <= rr_nxt;
            end
        end
    end

    assign bus.fu_ready_out = lane_rdy;
    assign bus.wb_valid_out = wb_vld_q;
    assign bus.wb_tag_out   = wb_q.tag;
    assign bus.wb_data_out  = wb_q.data;
    assign bus.wb_exc_out   = wb_q.exc;
    assign bus.wb_fu_out    = wb_fu_q;
endmodule
